// File: rtl/led_pio_pwm_if.sv
// Avalon-MM slave bus bundle for the LED PIO.
// Master drives address/strobes, slave returns readdata.
interface led_pio_pwm_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/led_pio_pwm.sv
// LED output port with set/clear, per-bit blink and global PWM.
// Zero-wait-state slave, combinational read, registered LED drive.
module led_pio_pwm #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 50000,
    parameter int PWM_BITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    led_pio_pwm_if.slave     bus,
    output logic [WIDTH-1:0] out_port
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    mode_q, mode_d;
    logic [15:0]         period_q, period_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PS_W-1:0]     pre_q, pre_d;
    logic [15:0]         blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]    out_q, out_d;

    logic             we;
    logic             period_wr;
    logic             tick;
    logic             pwm_on;
    logic [WIDTH-1:0] wd;
    logic             unused_wdata;

    assign we           = bus.chipselect & ~bus.write_n;
    assign wd           = bus.writedata[WIDTH-1:0];
    assign period_wr    = we && (bus.address == 3'd4);
    assign unused_wdata = ^bus.writedata;
    assign out_port     = out_q;

    // Register file updates from bus writes.
    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (we) begin
            case (bus.address)
                3'd0:    data_d   = wd;
                3'd1:    data_d   = data_q | wd;
                3'd2:    data_d   = data_q & ~wd;
                3'd3:    mode_d   = wd;
                3'd4:    period_d = bus.writedata[15:0];
                3'd5:    duty_d   = bus.writedata[PWM_BITS-1:0];
                default: ;
            endcase
        end
    end

    // Prescaler, blink phase and PWM counter.
    always_comb begin
        tick        = (pre_q == PS_LAST);
        pre_d       = tick ? '0 : pre_q + 1'b1;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        if (period_wr || period_q == 16'd0) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == period_q - 16'd1) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    // Output stage: blink gating then PWM gating.
    always_comb begin
        pwm_on = (duty_q == {PWM_BITS{1'b1}}) || (pwm_cnt_q < duty_q);
        out_d  = data_q & (~mode_q | {WIDTH{phase_q}});
        out_d  = out_d & {WIDTH{pwm_on}};
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            mode_q      <= '0;
            period_q    <= '0;
            duty_q      <= '1;
            pre_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            pwm_cnt_q   <= '0;
            out_q       <= '0;
        end else begin
            data_q      <= data_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            pre_q       <= pre_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pwm_cnt_q   <= pwm_cnt_d;
            out_q       <= out_d;
        end
    end

    // Combinational read mux.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata = 32'(data_q);
            3'd3:    bus.readdata = 32'(mode_q);
            3'd4:    bus.readdata = 32'(period_q);
            3'd5:    bus.readdata = 32'(duty_q);
            3'd6:    bus.readdata = 32'(out_q);
            default: bus.readdata = '0;
        endcase
    end
endmodule
